nf_seven_seg_scan_ctrl: RTL and testbench
=========================================

// Module: nf_seven_seg_scan_ctrl
// PURPOSE
//  Time-multiplexed seven-segment display controller with a memory-mapped register interface.
//  Sits on the nf_top peripheral bus beside gpio/pwm; the CPU writes a hex value, a dp mask and control bits.
//  An FSM scans hn digits with a blanking gap between digits (anti-ghosting).
//  The display value is shadowed once per frame so a mid-frame write never tears the display.
// PARAMETERS
//  hn     6      number of digits scanned (1..8)
//  DIV    50000  clk cycles each digit is lit (>=2)
//  BLANK  500    clk cycles all digits are dark between digits (>=1)
// PORTS
//  clk        in   1      system clock
//  resetn     in   1      asynchronous active-low reset
//  addr       in   2      register address: 0=VALUE, 1=DP, 2=CTRL, 3=reserved (reads 0, writes ignored)
//  we         in   1      write strobe, single cycle
//  wd         in   32     write data
//  rd         out  32     read data, registered, valid 1 cycle after addr is presented
//  seg        out  8      segments {dp,g,f,e,d,c,b,a}, polarity per CTRL.cc_ca
//  dig        out  hn     digit enables, one-hot when lit, polarity per CTRL.cc_ca
// BEHAVIOUR
//  Registers
//   - VALUE[4*hn-1:0]: nibble i drives digit i.
//   - DP[hn-1:0]: dp of digit i.
//   - CTRL[0]=en, CTRL[1]=cc_ca. Unused bits write-ignored and read 0.
//   - All registers reset to 0.
//  Polarity
//   - cc_ca=0: seg active-high, dig active-low.
//   - cc_ca=1: both inverted.
//   - "Dark" means seg all inactive and dig all inactive under the current cc_ca.
//   - A cc_ca change takes effect on the next clk.
//  Reset values: rd=0, state=IDLE, idx=0, cnt=0, shadow=0; seg=8'h00, dig='1 (dark for cc_ca=0).
//  FSM
//   - IDLE: outputs dark. When en=1: shadow<=VALUE/DP, idx<=0, cnt<=0, go to SHOW.
//   - SHOW: dig[idx] lit; seg=hex2seg(shadow nibble idx) | dp.
//     At cnt==DIV-1: cnt<=0, go to BLANK.
//   - BLANK: outputs dark. At cnt==BLANK-1: cnt<=0 and go to SHOW.
//     - idx==hn-1: idx wraps to 0 and shadow reloads from VALUE/DP (frame boundary).
//     - otherwise: idx<=idx+1.
//   - en=0 in any state: IDLE next cycle, idx<=0, cnt<=0, outputs dark from that cycle.
//  Outputs are registered: the lit digit changes exactly on state transitions, with no combinational glitch.
//  Frame period = hn*(DIV+BLANK) cycles.
//  Writes
//   - VALUE/DP writes mid-frame become visible only at the next frame boundary.
//   - A write in the same cycle as a reload is captured by that reload (write-through to shadow).
//  Read during write to the same address returns the old value.
//  Reset asserted mid-scan: all state returns to reset values immediately (async).
// CONFIGURATION
//  Macro NF_SEVEN_SEG_LZ_EN.
//   - Defined: leading-zero suppression. Digits above the most-significant nonzero shadow nibble
//     show seg dark (their dp still honoured).
//   - Digit 0 is never suppressed, so value 0 shows "0".
//   - Scan timing is unchanged.
//   - Undefined: every digit is displayed, including leading zeros.
// STRUCTURE
//  Package nf_seven_seg_pkg:
//   - state enum {IDLE,SHOW,BLANK};
//   - register address localparams NF_SSEG_VALUE/DP/CTRL;
//   - function hex2seg(nibble) -> 7-bit gfedcba table (active-high).
//  Sub-module nf_seven_seg_scan_cnt: DIV/BLANK cycle counter with terminal-count flag, reset and clear inputs.
//  The controller holds the registers, the shadow, the FSM, the LZ logic and output polarity.
// TESTING (bench params hn=4, DIV=4, BLANK=2, cc_ca=0)
//  1. Reset, no writes -> seg=8'h00, dig=4'b1111 held; reads of addr 0..3 all return 0.
//  2. Write VALUE=32'h0000_2019, CTRL=1
//     -> dig sequence 1110,dark,1101,dark,1011,dark,0111,dark.
//     -> seg 0x6F(9),0x06(1),0x3F(0),0x5B(2); each digit lit 4 cycles, dark 2; frame = 24 cycles.
//  3. Mid-frame (idx=1) write VALUE=16'hABCD
//     -> remainder of frame still shows 2019; next frame shows D,C,B,A; rd at addr 0 reads 0xABCD.
//  4. Clear en during SHOW idx=2 -> dark on the next cycle.
//     Set en again -> restarts at idx 0 with fresh shadow.
//  5. CTRL=3 (cc_ca=1), DP=4'b0001 -> digit 0 seg=~(0x6F|0x80), dig=4'b0001.
//     Dark state is seg=8'hFF, dig=4'b0000.
//  6. With NF_SEVEN_SEG_LZ_EN, VALUE=16'h0007 -> digits 3..1 seg dark, digit 0 seg=0x07.
//     VALUE=0 -> digit 0 shows 0x3F.

Source files
------------

// File: rtl/nf_seven_seg_pkg.sv
// rtl/nf_seven_seg_pkg.sv - shared types, register map and hex decoder for the seven-segment scanner
package nf_seven_seg_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHOW  = 2'd1,
    BLANK = 2'd2
  } state_t;

  localparam logic [1:0] NF_SSEG_VALUE = 2'd0;
  localparam logic [1:0] NF_SSEG_DP    = 2'd1;
  localparam logic [1:0] NF_SSEG_CTRL  = 2'd2;

  // Active-high segment pattern, bit order {g,f,e,d,c,b,a}.
  function automatic logic [6:0] hex2seg(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'h0: s = 7'h3F;
      4'h1: s = 7'h06;
      4'h2: s = 7'h5B;
      4'h3: s = 7'h4F;
      4'h4: s = 7'h66;
      4'h5: s = 7'h6D;
      4'h6: s = 7'h7D;
      4'h7: s = 7'h07;
      4'h8: s = 7'h7F;
      4'h9: s = 7'h6F;
      4'hA: s = 7'h77;
      4'hB: s = 7'h7C;
      4'hC: s = 7'h39;
      4'hD: s = 7'h5E;
      4'hE: s = 7'h79;
      default: s = 7'h71;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/nf_seven_seg_scan_cnt.sv
// rtl/nf_seven_seg_scan_cnt.sv - lit/blank interval counter with terminal-count flag
module nf_seven_seg_scan_cnt #(
  parameter int DIV   = 50000,
  parameter int BLANK = 500
) (
  input  logic clk,
  input  logic resetn,
  input  logic clr,
  input  logic sel_blank,
  output logic tc
);

  localparam int MAXC = (DIV > BLANK) ? DIV : BLANK;
  localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;
  localparam logic [CW-1:0] DIV_TC   = CW'(DIV - 1);
  localparam logic [CW-1:0] BLANK_TC = CW'(BLANK - 1);

  logic [CW-1:0] cnt;

  assign tc = (cnt == (sel_blank ? BLANK_TC : DIV_TC));

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt <= '0;
    end else if (clr || tc) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/nf_seven_seg_scan_ctrl.sv
// rtl/nf_seven_seg_scan_ctrl.sv - scanned seven-segment controller; NF_SEVEN_SEG_LZ_EN enables leading-zero suppression
module nf_seven_seg_scan_ctrl #(
  parameter int hn    = 6,
  parameter int DIV   = 50000,
  parameter int BLANK = 500
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic [1:0]    addr,
  input  logic          we,
  input  logic [31:0]   wd,
  output logic [31:0]   rd,
  output logic [7:0]    seg,
  output logic [hn-1:0] dig
);
  import nf_seven_seg_pkg::*;

  localparam int VW = 4 * hn;
  localparam int IW = (hn > 1) ? $clog2(hn) : 1;
  localparam logic [IW-1:0] LAST = IW'(hn - 1);

  logic [VW-1:0] value_q, value_nxt, shadow_val, show_val;
  logic [hn-1:0] dp_q, dp_nxt, shadow_dp, show_dp;
  logic [1:0]    ctrl_q;
  logic          en, cc_ca, wr_value, wr_dp, wr_ctrl;
  state_t        state;
  logic [IW-1:0] idx, show_idx;
  logic          reload, tc, blank_seg;
  logic [3:0]    nib;
  logic [7:0]    seg_hi, lit_seg, dark_seg;
  logic [hn-1:0] onehot, lit_dig, dark_dig;
  logic          unused_ok;

  assign en        = ctrl_q[0];
  assign cc_ca     = ctrl_q[1];
  assign wr_value  = we && (addr == NF_SSEG_VALUE);
  assign wr_dp     = we && (addr == NF_SSEG_DP);
  assign wr_ctrl   = we && (addr == NF_SSEG_CTRL);
  assign unused_ok = ^wd;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      value_q <= '0;
      dp_q    <= '0;
      ctrl_q  <= '0;
      rd      <= '0;
    end else begin
      if (wr_value) value_q <= wd[VW-1:0];
      if (wr_dp)    dp_q    <= wd[hn-1:0];
      if (wr_ctrl)  ctrl_q  <= wd[1:0];
      case (addr)
        NF_SSEG_VALUE: rd <= 32'(value_q);
        NF_SSEG_DP:    rd <= 32'(dp_q);
        NF_SSEG_CTRL:  rd <= 32'(ctrl_q);
        default:       rd <= '0;
      endcase
    end
  end

  nf_seven_seg_scan_cnt #(.DIV(DIV), .BLANK(BLANK)) u_cnt (
    .clk       (clk),
    .resetn    (resetn),
    .clr       (!en || (state == IDLE)),
    .sel_blank (state == nf_seven_seg_pkg::BLANK),
    .tc        (tc)
  );

  // Everything below describes the digit that will be lit after the next
  // transition into SHOW, so outputs can be registered alongside the state.
  // A same-cycle register write is forwarded into a frame reload.
  always_comb begin
    value_nxt = wr_value ? wd[VW-1:0] : value_q;
    dp_nxt    = wr_dp ? wd[hn-1:0] : dp_q;
    reload    = (state == IDLE) || ((state == nf_seven_seg_pkg::BLANK) && (idx == LAST));
    show_idx  = '0;
    case (state)
      SHOW:                   show_idx = idx;
      nf_seven_seg_pkg::BLANK: show_idx = reload ? '0 : idx + IW'(1);
      default:                show_idx = '0;
    endcase
    show_val = reload ? value_nxt : shadow_val;
    show_dp  = reload ? dp_nxt : shadow_dp;
    nib      = show_val[4*show_idx +: 4];
`ifdef NF_SEVEN_SEG_LZ_EN
    begin
      logic [IW-1:0] msnz;
      msnz = '0;
      for (int i = 1; i < hn; i++) begin
        if (show_val[4*i +: 4] != 4'h0) msnz = IW'(i);
      end
      blank_seg = (show_idx > msnz);
    end
`else
    blank_seg = 1'b0;
`endif
    seg_hi           = {show_dp[show_idx], blank_seg ? 7'h00 : hex2seg(nib)};
    onehot           = '0;
    onehot[show_idx] = 1'b1;
    lit_seg          = cc_ca ? ~seg_hi : seg_hi;
    lit_dig          = cc_ca ? onehot : ~onehot;
    dark_seg         = {8{cc_ca}};
    dark_dig         = {hn{~cc_ca}};
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state      <= IDLE;
      idx        <= '0;
      shadow_val <= '0;
      shadow_dp  <= '0;
      seg        <= 8'h00;
      dig        <= '1;
    end else if (!en) begin
      state <= IDLE;
      idx   <= '0;
      seg   <= dark_seg;
      dig   <= dark_dig;
    end else begin
      case (state)
        IDLE: begin
          state      <= SHOW;
          idx        <= '0;
          shadow_val <= show_val;
          shadow_dp  <= show_dp;
          seg        <= lit_seg;
          dig        <= lit_dig;
        end
        SHOW: begin
          if (tc) begin
            state <= nf_seven_seg_pkg::BLANK;
            seg   <= dark_seg;
            dig   <= dark_dig;
          end else begin
            seg <= lit_seg;
            dig <= lit_dig;
          end
        end
        nf_seven_seg_pkg::BLANK: begin
          if (tc) begin
            state      <= SHOW;
            idx        <= show_idx;
            shadow_val <= show_val;
            shadow_dp  <= show_dp;
            seg        <= lit_seg;
            dig        <= lit_dig;
          end else begin
            seg <= dark_seg;
            dig <= dark_dig;
          end
        end
        default: begin
          state <= IDLE;
          seg   <= dark_seg;
          dig   <= dark_dig;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_nf_seven_seg_scan_ctrl.sv
// tb/tb_nf_seven_seg_scan_ctrl.sv - directed self-checking bench for nf_seven_seg_scan_ctrl
module tb_nf_seven_seg_scan_ctrl;

  localparam int HN  = 4;
  localparam int DIV = 4;
  localparam int BLK = 2;
  localparam int SLOT = DIV + BLK;

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic [1:0]    addr = 2'd0;
  logic          we = 1'b0;
  logic [31:0]   wd = 32'h0;
  logic [31:0]   rd;
  logic [7:0]    seg;
  logic [HN-1:0] dig;

  int checks = 0;
  int failures = 0;

  nf_seven_seg_scan_ctrl #(.hn(HN), .DIV(DIV), .BLANK(BLK)) dut (
    .clk    (clk),
    .resetn (resetn),
    .addr   (addr),
    .we     (we),
    .wd     (wd),
    .rd     (rd),
    .seg    (seg),
    .dig    (dig)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [1:0]  addr;
    logic [31:0] wd;
    logic [31:0] rd;
  } vec_t;

  vec_t vt[16];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    addr = a;
    wd   = d;
    we   = 1'b1;
    cyc();
    we   = 1'b0;
  endtask

  function automatic logic [6:0] ref_seg(input logic [3:0] n);
    logic [6:0] t [16];
    t = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
          7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
    return t[n];
  endfunction

  function automatic logic [7:0] exp_seg(input logic [15:0] v, input logic [3:0] dp,
                                         input logic cc, input int d);
    logic [7:0] s;
    s = {dp[d], ref_seg(v[4*d +: 4])};
`ifdef NF_SEVEN_SEG_LZ_EN
    begin
      int ms;
      ms = 0;
      for (int i = 1; i < HN; i++) if (v[4*i +: 4] != 4'h0) ms = i;
      if (d > ms) s[6:0] = 7'h00;
    end
`endif
    return cc ? ~s : s;
  endfunction

  task automatic check_dark(input string name, input logic cc);
    check({name, "_seg"}, {24'h0, seg}, cc ? 32'hFF : 32'h00);
    check({name, "_dig"}, {28'h0, dig}, cc ? 32'h0 : 32'hF);
  endtask

  // Steps npos cycles of a frame starting from its first lit cycle,
  // optionally issuing one register write on the edge of position wr_pos.
  task automatic run_frame(input string tag, input logic [15:0] v, input logic [3:0] dp,
                           input logic cc, input int npos, input int wr_pos,
                           input logic [1:0] wa, input logic [31:0] wdat);
    for (int p = 0; p < npos; p++) begin
      if (p == wr_pos) begin
        addr = wa;
        wd   = wdat;
        we   = 1'b1;
      end
      cyc();
      we = 1'b0;
      if ((p % SLOT) < DIV) begin
        logic [3:0] oh;
        oh = 4'b0001 << (p / SLOT);
        check($sformatf("%s_p%0d_seg", tag, p), {24'h0, seg}, {24'h0, exp_seg(v, dp, cc, p / SLOT)});
        check($sformatf("%s_p%0d_dig", tag, p), {28'h0, dig}, {28'h0, cc ? oh : ~oh});
      end else begin
        check_dark($sformatf("%s_p%0d", tag, p), cc);
      end
    end
  endtask

  initial begin
    vt[0]  = '{1'b0, 2'd0, 32'h0000_0000, 32'h0000_0000};
    vt[1]  = '{1'b0, 2'd1, 32'h0000_0000, 32'h0000_0000};
    vt[2]  = '{1'b0, 2'd2, 32'h0000_0000, 32'h0000_0000};
    vt[3]  = '{1'b0, 2'd3, 32'h0000_0000, 32'h0000_0000};
    vt[4]  = '{1'b1, 2'd0, 32'h1234_5678, 32'h0000_0000};
    vt[5]  = '{1'b0, 2'd0, 32'h0000_0000, 32'h0000_5678};
    vt[6]  = '{1'b1, 2'd1, 32'hFFFF_FFFF, 32'h0000_0000};
    vt[7]  = '{1'b0, 2'd1, 32'h0000_0000, 32'h0000_000F};
    vt[8]  = '{1'b1, 2'd3, 32'hFFFF_FFFF, 32'h0000_0000};
    vt[9]  = '{1'b0, 2'd3, 32'h0000_0000, 32'h0000_0000};
    vt[10] = '{1'b1, 2'd2, 32'hFFFF_FFFC, 32'h0000_0000};
    vt[11] = '{1'b0, 2'd2, 32'h0000_0000, 32'h0000_0000};
    vt[12] = '{1'b1, 2'd0, 32'h0000_0000, 32'h0000_5678};
    vt[13] = '{1'b1, 2'd1, 32'h0000_0000, 32'h0000_000F};
    vt[14] = '{1'b0, 2'd0, 32'h0000_0000, 32'h0000_0000};
    vt[15] = '{1'b0, 2'd1, 32'h0000_0000, 32'h0000_0000};

    cyc();
    check("rst_rd", rd, 32'h0);
    check_dark("rst", 1'b0);
    cyc();
    resetn = 1'b1;
    cyc();
    check_dark("post_rst", 1'b0);

    for (int i = 0; i < 16; i++) begin
      addr = vt[i].addr;
      wd   = vt[i].wd;
      we   = vt[i].we;
      cyc();
      we   = 1'b0;
      check($sformatf("reg_v%0d_rd", i), rd, vt[i].rd);
      check_dark($sformatf("reg_v%0d", i), 1'b0);
    end

    wr(2'd0, 32'h0000_2019);
    wr(2'd2, 32'h0000_0001);
    check_dark("en_idle", 1'b0);
    run_frame("f2019a", 16'h2019, 4'h0, 1'b0, 24, -1, 2'd0, 32'h0);

    run_frame("f2019b", 16'h2019, 4'h0, 1'b0, 24, 7, 2'd0, 32'h0000_ABCD);
    check("rd_value", rd, 32'h0000_ABCD);
    run_frame("fabcd", 16'hABCD, 4'h0, 1'b0, 24, -1, 2'd0, 32'h0);
    run_frame("fthru", 16'h5AF0, 4'h0, 1'b0, 24, 0, 2'd0, 32'h0000_5AF0);

    run_frame("fstop", 16'h5AF0, 4'h0, 1'b0, 13, -1, 2'd0, 32'h0);
    wr(2'd2, 32'h0);
    cyc();
    check_dark("stop1", 1'b0);
    wr(2'd0, 32'h0000_4321);
    check_dark("stop2", 1'b0);
    wr(2'd2, 32'h0000_0001);
    run_frame("f4321", 16'h4321, 4'h0, 1'b0, 24, -1, 2'd0, 32'h0);

    wr(2'd2, 32'h0);
    cyc();
    check_dark("stop3", 1'b0);
    wr(2'd0, 32'h0000_2019);
    wr(2'd1, 32'h0000_0001);
    wr(2'd2, 32'h0000_0003);
    run_frame("fccca", 16'h2019, 4'h1, 1'b1, 24, -1, 2'd0, 32'h0);

    wr(2'd2, 32'h0);
    cyc();
    check_dark("stop4", 1'b0);
    wr(2'd0, 32'h0000_0007);
    wr(2'd1, 32'h0);
    wr(2'd2, 32'h0000_0001);
    run_frame("f0007", 16'h0007, 4'h0, 1'b0, 24, -1, 2'd0, 32'h0);
    run_frame("f0000", 16'h0000, 4'h0, 1'b0, 24, 0, 2'd0, 32'h0);

    run_frame("fpre", 16'h0000, 4'h0, 1'b0, 3, -1, 2'd0, 32'h0);
    #2;
    resetn = 1'b0;
    #1;
    check_dark("async_rst", 1'b0);
    cyc();
    resetn = 1'b1;
    addr   = 2'd0;
    cyc();
    check("rst2_rd0", rd, 32'h0);
    addr = 2'd2;
    cyc();
    check("rst2_rd2", rd, 32'h0);
    check_dark("rst2_idle", 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
